// File: rtl/mips_pipe_cpu.sv
// 5-stage MIPS-subset pipeline (IF/ID/EX/MEM/WB), Harvard buses, no forwarding or interlock.
// Define MUL_EN to implement MUL (opcode 0x1C, funct 0x02); otherwise it decodes as NOP.
module mips_pipe_cpu #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned NREGS    = 32
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [31:0] Prog_BUS_READ,
   input  logic [31:0] Data_BUS_READ,
   output logic [31:0] ADDR_Prog,
   output logic        CS_P,
   output logic [31:0] ADDR,
   output logic [31:0] Data_BUS_WRITE,
   output logic        CS,
   output logic        WE
);

   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL} alu_op_e;

   typedef struct packed {
      alu_op_e     op;
      logic [31:0] a, b, rtv, imm, pc;
      logic [4:0]  dst;
      logic        wr, ld, st, br;
   } idex_t;

   typedef struct packed {
      logic [31:0] addr, wdata, res;
      logic [4:0]  dst;
      logic        wr, ld, cs, we;
   } exmem_t;

   logic [31:0] pc_q, pc_d;
   logic        run_q, run_d;
   logic [31:0] ifid_ir_q, ifid_ir_d, ifid_pc_q, ifid_pc_d;
   idex_t       idex_q, idex_d;
   exmem_t      exmem_q, exmem_d;
   logic [31:0] wb_val_q, wb_val_d;
   logic [4:0]  wb_dst_q, wb_dst_d;
   logic        wb_wr_q, wb_wr_d;
   logic [31:0] rf_q [NREGS];
   logic [31:0] rf_d [NREGS];
   logic [31:0] writeBack;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, id_dst;
   logic [31:0] sext, zext, rs_val, rt_val, alu_res, br_target;
   logic        id_wr, jump, br_taken;

   assign opcode = ifid_ir_q[31:26];
   assign rs     = ifid_ir_q[25:21];
   assign rt     = ifid_ir_q[20:16];
   assign rd     = ifid_ir_q[15:11];
   assign funct  = ifid_ir_q[5:0];
   assign sext   = {{16{ifid_ir_q[15]}}, ifid_ir_q[15:0]};
   assign zext   = {16'h0000, ifid_ir_q[15:0]};

   // Write-before-read: WB only ever holds a nonzero destination, so r0 never bypasses.
   assign rs_val = (wb_wr_q && wb_dst_q == rs) ? wb_val_q : rf_q[rs];
   assign rt_val = (wb_wr_q && wb_dst_q == rt) ? wb_val_q : rf_q[rt];

   always_comb begin
      idex_d     = '0;
      idex_d.op  = ALU_ADD;
      idex_d.a   = rs_val;
      idex_d.b   = rt_val;
      idex_d.rtv = rt_val;
      idex_d.imm = sext;
      idex_d.pc  = ifid_pc_q;
      id_wr      = 1'b0;
      id_dst     = rt;
      jump       = 1'b0;
      case (opcode)
         6'h00: begin
            id_dst = rd;
            id_wr  = 1'b1;
            case (funct)
               6'h20:   idex_d.op = ALU_ADD;
               6'h22:   idex_d.op = ALU_SUB;
               6'h24:   idex_d.op = ALU_AND;
               6'h25:   idex_d.op = ALU_OR;
               6'h2A:   idex_d.op = ALU_SLT;
               default: id_wr = 1'b0;
            endcase
         end
         6'h08: begin idex_d.b = sext; id_wr = 1'b1; end
         6'h0C: begin idex_d.op = ALU_AND; idex_d.b = zext; id_wr = 1'b1; end
         6'h0D: begin idex_d.op = ALU_OR;  idex_d.b = zext; id_wr = 1'b1; end
         6'h23: begin idex_d.b = sext; id_wr = 1'b1; idex_d.ld = 1'b1; end
         6'h2B: begin idex_d.b = sext; idex_d.st = 1'b1; end
         6'h04: idex_d.br = 1'b1;
         6'h02: jump = 1'b1;
`ifdef MUL_EN
         6'h1C: begin
            if (funct == 6'h02) begin
               idex_d.op = ALU_MUL;
               id_dst    = rd;
               id_wr     = 1'b1;
            end
         end
`endif
         default: ;
      endcase
      idex_d.dst = id_dst;
      idex_d.wr  = id_wr && (id_dst != 5'd0);
      if (br_taken) idex_d = '0;
   end

   always_comb begin
      case (idex_q.op)
         ALU_ADD: alu_res = idex_q.a + idex_q.b;
         ALU_SUB: alu_res = idex_q.a - idex_q.b;
         ALU_AND: alu_res = idex_q.a & idex_q.b;
         ALU_OR:  alu_res = idex_q.a | idex_q.b;
         ALU_SLT: alu_res = {31'd0, $signed(idex_q.a) < $signed(idex_q.b)};
`ifdef MUL_EN
         ALU_MUL: alu_res = idex_q.a * idex_q.b;
`endif
         default: alu_res = idex_q.a + idex_q.b;
      endcase
   end

   assign br_taken  = idex_q.br && (idex_q.a == idex_q.rtv);
   assign br_target = idex_q.pc + 32'd1 + idex_q.imm;

   always_comb begin
      exmem_d       = '0;
      exmem_d.res   = alu_res;
      exmem_d.addr  = (idex_q.ld || idex_q.st) ? alu_res : '0;
      exmem_d.wdata = idex_q.st ? idex_q.rtv : '0;
      exmem_d.cs    = idex_q.ld || idex_q.st;
      exmem_d.we    = idex_q.st;
      exmem_d.ld    = idex_q.ld;
      exmem_d.wr    = idex_q.wr;
      exmem_d.dst   = idex_q.dst;
   end

   always_comb begin
      run_d     = 1'b1;
      pc_d      = pc_q + 32'd1;
      ifid_pc_d = pc_q;
      ifid_ir_d = Prog_BUS_READ;
      // A taken branch in EX outranks a jump in ID; either flushes the fetch.
      if (br_taken)  pc_d = br_target;
      else if (jump) pc_d = {ifid_pc_q[31:26], ifid_ir_q[25:0]};
      if (br_taken || jump) ifid_ir_d = '0;
      wb_val_d = exmem_q.ld ? Data_BUS_READ : exmem_q.res;
      wb_dst_d = exmem_q.dst;
      wb_wr_d  = exmem_q.wr;
      rf_d     = rf_q;
      if (wb_wr_q) rf_d[wb_dst_q] = wb_val_q;
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         pc_q      <= RESET_PC;
         run_q     <= 1'b0;
         ifid_ir_q <= '0;
         ifid_pc_q <= '0;
         idex_q    <= '0;
         exmem_q   <= '0;
         wb_val_q  <= '0;
         wb_dst_q  <= '0;
         wb_wr_q   <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         pc_q      <= pc_d;
         run_q     <= run_d;
         ifid_ir_q <= ifid_ir_d;
         ifid_pc_q <= ifid_pc_d;
         idex_q    <= idex_d;
         exmem_q   <= exmem_d;
         wb_val_q  <= wb_val_d;
         wb_dst_q  <= wb_dst_d;
         wb_wr_q   <= wb_wr_d;
         rf_q      <= rf_d;
      end
   end

   assign writeBack      = wb_val_q;
   assign ADDR_Prog      = pc_q;
   assign CS_P           = run_q;
   assign ADDR           = exmem_q.addr;
   assign Data_BUS_WRITE = exmem_q.wdata;
   assign CS             = exmem_q.cs;
   assign WE             = exmem_q.we;

endmodule

// File: tb/tb_mips_pipe_cpu.sv
// Directed bench for mips_pipe_cpu: program memory model, bus-activity log, immediate assertions.
module tb_mips_pipe_cpu;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] Prog_BUS_READ, Data_BUS_READ;
   logic [31:0] ADDR_Prog, ADDR, Data_BUS_WRITE;
   logic        CS_P, CS, WE;

   logic [31:0] imem [64];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic [31:0] st_a [$];
   logic [31:0] st_d [$];
   int          st_c [$];
   logic [31:0] ld_a [$];
   int          ld_c [$];
   int          exp_pc [6];
   logic [31:0] mul_exp;

   always #5 CLK = ~CLK;

   always_comb Prog_BUS_READ = (ADDR_Prog < 32'd64) ? imem[ADDR_Prog[5:0]] : 32'h0;

   mips_pipe_cpu #(.RESET_PC(32'h0), .NREGS(32)) dut (
      .CLK(CLK), .Reset(Reset),
      .Prog_BUS_READ(Prog_BUS_READ), .Data_BUS_READ(Data_BUS_READ),
      .ADDR_Prog(ADDR_Prog), .CS_P(CS_P),
      .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE), .CS(CS), .WE(WE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 ns after the edge, log every data-bus access by cycle number.
   task automatic step();
      @(posedge CLK);
      #1;
      cyc++;
      if (CS && WE) begin
         st_a.push_back(ADDR);
         st_d.push_back(Data_BUS_WRITE);
         st_c.push_back(cyc);
      end
      if (CS && !WE) begin
         ld_a.push_back(ADDR);
         ld_c.push_back(cyc);
      end
   endtask

   task automatic restart();
      Reset = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      cyc = 0;
      st_a.delete(); st_d.delete(); st_c.delete();
      ld_a.delete(); ld_c.delete();
   endtask

   task automatic clear_imem();
      foreach (imem[i]) imem[i] = 32'h0;
   endtask

   task automatic load_store_prog();
      clear_imem();
      imem[0] = 32'h2001_0005;   // ADDI r1,r0,5
      imem[1] = 32'h2000_0009;   // ADDI r0,r0,9
      imem[3] = 32'hAC01_0011;   // SW r1,0x11(r0)  (3 after producer)
      imem[4] = 32'hAC01_0010;   // SW r1,0x10(r0)
      imem[5] = 32'hAC00_0012;   // SW r0,0x12(r0)
   endtask

   initial begin
      clear_imem();
      Data_BUS_READ = 32'hFFFF_FFFF;

      // reset values
      @(posedge CLK);
      #1;
      chk("rst ADDR_Prog", ADDR_Prog, 32'h0);
      chk("rst CS_P", {31'd0, CS_P}, 32'd0);
      chk("rst CS", {31'd0, CS}, 32'd0);
      chk("rst WE", {31'd0, WE}, 32'd0);
      chk("rst ADDR", ADDR, 32'h0);
      chk("rst DBW", Data_BUS_WRITE, 32'h0);
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      chk("rel ADDR_Prog", ADDR_Prog, 32'h0);

      // all-NOP stream
      for (int k = 1; k <= 8; k++) begin
         step();
         chk("nop pc", ADDR_Prog, k);
         chk("nop CS_P", {31'd0, CS_P}, 32'd1);
         chk("nop CS", {31'd0, CS}, 32'd0);
         chk("nop WE", {31'd0, WE}, 32'd0);
         chk("nop DBW", Data_BUS_WRITE, 32'h0);
      end

      // ADDI then stores, incl. minimum spacing and r0 write suppression
      load_store_prog();
      restart();
      repeat (12) step();
      chk("st count", st_a.size(), 3);
      chk("st0 addr", st_a[0], 32'h11);
      chk("st0 data", st_d[0], 32'h5);
      chk("st0 cyc", st_c[0], 6);
      chk("st1 addr", st_a[1], 32'h10);
      chk("st1 data", st_d[1], 32'h5);
      chk("st1 cyc", st_c[1], 7);
      chk("st2 addr", st_a[2], 32'h12);
      chk("st2 r0 data", st_d[2], 32'h0);
      chk("st ld count", ld_a.size(), 0);

      // LW then SW of the loaded value
      clear_imem();
      imem[0] = 32'h8C02_0020;
      imem[4] = 32'hAC02_0030;
      restart();
      repeat (10) step();
      chk("lw count", ld_a.size(), 1);
      chk("lw addr", ld_a[0], 32'h20);
      chk("lw cyc", ld_c[0], 3);
      chk("lw st count", st_a.size(), 1);
      chk("lw st addr", st_a[0], 32'h30);
      chk("lw st data", st_d[0], 32'hFFFF_FFFF);
      chk("lw st cyc", st_c[0], 7);

      // SLT signed, SUB, ANDI zero-extend
      clear_imem();
      imem[0] = 32'h2001_FFFD;   // r1 = -3
      imem[1] = 32'h2002_0004;   // r2 = 4
      imem[4] = 32'h0022_182A;   // SLT r3,r1,r2
      imem[5] = 32'h0041_2822;   // SUB r5,r2,r1
      imem[6] = 32'h3026_FFF0;   // ANDI r6,r1,0xFFF0
      imem[7] = 32'hAC03_0080;
      imem[8] = 32'hAC05_0081;
      imem[9] = 32'hAC06_0082;
      restart();
      repeat (14) step();
      chk("alu st count", st_a.size(), 3);
      chk("slt data", st_d[0], 32'h1);
      chk("slt cyc", st_c[0], 10);
      chk("sub data", st_d[1], 32'h7);
      chk("andi data", st_d[2], 32'h0000_FFF0);
      chk("andi addr", st_a[2], 32'h82);

      // BEQ r0,r0,+4 at PC 2
      clear_imem();
      imem[2] = 32'h1000_0004;
      imem[3] = 32'hAC00_0040;
      imem[4] = 32'hAC00_0041;
      imem[5] = 32'hAC00_0042;
      imem[6] = 32'hAC00_0043;
      imem[7] = 32'hAC00_0050;
      restart();
      #1;
      chk("beq pc0", ADDR_Prog, 32'h0);
      exp_pc = '{1, 2, 3, 4, 7, 8};
      for (int i = 0; i < 6; i++) begin
         step();
         chk("beq pc", ADDR_Prog, exp_pc[i]);
      end
      repeat (6) step();
      chk("beq st count", st_a.size(), 1);
      chk("beq st addr", st_a[0], 32'h50);
      chk("beq st cyc", st_c[0], 8);

      // J 10 at PC 1
      clear_imem();
      imem[1]  = 32'h0800_000A;
      imem[2]  = 32'hAC00_0060;
      imem[10] = 32'hAC00_0061;
      restart();
      step(); chk("j pc1", ADDR_Prog, 32'd1);
      step(); chk("j pc2", ADDR_Prog, 32'd2);
      step(); chk("j pc3", ADDR_Prog, 32'd10);
      step(); chk("j pc4", ADDR_Prog, 32'd11);
      repeat (6) step();
      chk("j st count", st_a.size(), 1);
      chk("j st addr", st_a[0], 32'h61);
      chk("j st cyc", st_c[0], 6);

      // MUL r4,r1,r3 with r1=6, r3=7
      clear_imem();
      imem[0] = 32'h2001_0006;
      imem[1] = 32'h2003_0007;
      imem[4] = 32'h7023_2002;
      imem[7] = 32'hAC04_0070;
`ifdef MUL_EN
      mul_exp = 32'h0000_002A;
`else
      mul_exp = 32'h0;
`endif
      restart();
      repeat (12) step();
      chk("mul st count", st_a.size(), 1);
      chk("mul st addr", st_a[0], 32'h70);
      chk("mul st data", st_d[0], mul_exp);
      chk("mul st cyc", st_c[0], 10);

      // reset while a SW is in MEM
      load_store_prog();
      restart();
      repeat (7) step();
      chk("mid CS", {31'd0, CS}, 32'd1);
      chk("mid WE", {31'd0, WE}, 32'd1);
      chk("mid ADDR", ADDR, 32'h10);
      #1;
      Reset = 1'b1;
      #1;
      chk("mid rst CS", {31'd0, CS}, 32'd0);
      chk("mid rst WE", {31'd0, WE}, 32'd0);
      chk("mid rst ADDR", ADDR, 32'h0);
      chk("mid rst DBW", Data_BUS_WRITE, 32'h0);
      chk("mid rst pc", ADDR_Prog, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      cyc = 0;
      #1;
      chk("mid rel pc", ADDR_Prog, 32'h0);
      step();
      chk("mid pc1", ADDR_Prog, 32'h1);
      chk("mid CS_P", {31'd0, CS_P}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
